// File: rtl/y_serial_adder.sv
// y_serial_adder: multi-cycle ripple adder processing DIGIT bits per clock.
// A single DIGIT-wide adder slice and a registered carry walk the operands
// from LSB to MSB over N = SIZE/DIGIT cycles; start/busy/done sequence it.
// Optional feature macro: SERIAL_ADDER_SUB_EN (enables subtract mode via 'sub').
module y_serial_adder #(
  parameter int SIZE  = 32,
  parameter int DIGIT = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            cin,
  input  logic            sub,
  output logic            busy,
  output logic            done,
  output logic [SIZE-1:0] z,
  output logic            cout,
  output logic            ovf
);

  localparam int N  = SIZE / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [SIZE-1:0]   a_r;
  logic [SIZE-1:0]   b_r;
  logic [SIZE-1:0]   zsh_r;
  logic [SIZE-1:0]   z_r;
  logic              carry_r;
  logic [CW-1:0]     cnt_r;
  logic              busy_r;
  logic              done_r;
  logic              cout_r;
  logic              ovf_r;

  logic              capture_s;
  logic              last_s;
  logic [DIGIT:0]    slice_s;
  logic [SIZE+DIGIT-1:0] zcat_s;
  logic              msb_cin_s;
  logic [SIZE-1:0]   b_load_s;
  logic              carry_load_s;

`ifdef SERIAL_ADDER_SUB_EN
  // Operand B and initial carry as loaded at capture: inverted B plus 1 for subtraction.
  always_comb begin
    b_load_s     = b;
    carry_load_s = cin;
    if (sub) begin
      b_load_s     = ~b;
      carry_load_s = 1'b1;
    end else begin
      b_load_s     = b;
      carry_load_s = cin;
    end
  end
`else
  // Subtraction not built: B and cin load unchanged, sub is deliberately unused.
  logic unused_sub_s;
  assign unused_sub_s = sub;
  assign b_load_s     = b;
  assign carry_load_s = cin;
`endif

  // Adder slice, shift-in of the new sum digit, and carry into the top result bit.
  always_comb begin
    slice_s   = {1'b0, a_r[DIGIT-1:0]} + {1'b0, b_r[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_r};
    zcat_s    = {slice_s[DIGIT-1:0], zsh_r};
    msb_cin_s = a_r[DIGIT-1] ^ b_r[DIGIT-1] ^ slice_s[DIGIT-1];
    last_s    = (cnt_r == LAST);
  end

  // Next-state logic and operand-capture decode.
  always_comb begin
    state_s   = state_r;
    capture_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s   = RUN;
          capture_s = 1'b1;
        end else begin
          state_s   = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        if (start) begin
          state_s   = RUN;
          capture_s = 1'b1;
        end else begin
          state_s   = IDLE;
        end
      end
      default: begin
        state_s   = IDLE;
        capture_s = 1'b0;
      end
    endcase
  end

  // State register plus registered busy/done decodes of the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == RUN);
      done_r  <= (state_s == DONE);
    end
  end

  // Datapath: capture operands, step one digit per RUN cycle, publish result on entry to DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_r     <= '0;
      b_r     <= '0;
      zsh_r   <= '0;
      z_r     <= '0;
      carry_r <= 1'b0;
      cnt_r   <= '0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else if (capture_s) begin
      a_r     <= a;
      b_r     <= b_load_s;
      carry_r <= carry_load_s;
      cnt_r   <= '0;
    end else if (state_r == RUN) begin
      a_r     <= a_r >> DIGIT;
      b_r     <= b_r >> DIGIT;
      zsh_r   <= zcat_s[SIZE+DIGIT-1:DIGIT];
      carry_r <= slice_s[DIGIT];
      cnt_r   <= cnt_r + CW'(1);
      if (last_s) begin
        z_r    <= zcat_s[SIZE+DIGIT-1:DIGIT];
        cout_r <= slice_s[DIGIT];
        ovf_r  <= msb_cin_s ^ slice_s[DIGIT];
      end else begin
        z_r    <= z_r;
        cout_r <= cout_r;
        ovf_r  <= ovf_r;
      end
    end else begin
      a_r     <= a_r;
      b_r     <= b_r;
      carry_r <= carry_r;
      cnt_r   <= cnt_r;
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign z    = z_r;
  assign cout = cout_r;
  assign ovf  = ovf_r;

endmodule

// File: tb/tb_y_serial_adder.sv
// Self-checking bench for y_serial_adder: four instances of different
// SIZE/DIGIT share operands, each with its own start; a table of directed
// vectors, hand-written multi-cycle sequences and random operations are
// checked against an arithmetic reference model.
module tb_y_serial_adder;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] start_v;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic       cin_in;
  logic       sub_in;
  logic [3:0] busy_v;
  logic [3:0] done_v;
  logic [3:0] cout_v;
  logic [3:0] ovf_v;
  logic [7:0] z_v [4];
  logic [0:0] z_c;

  int errors = 0;
  int checks = 0;

`ifdef SERIAL_ADDER_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  y_serial_adder #(.SIZE(8), .DIGIT(1)) u_a (
    .clk(clk), .reset(reset), .start(start_v[0]), .a(a_in), .b(b_in), .cin(cin_in), .sub(sub_in),
    .busy(busy_v[0]), .done(done_v[0]), .z(z_v[0]), .cout(cout_v[0]), .ovf(ovf_v[0]));
  y_serial_adder #(.SIZE(8), .DIGIT(4)) u_b (
    .clk(clk), .reset(reset), .start(start_v[1]), .a(a_in), .b(b_in), .cin(cin_in), .sub(sub_in),
    .busy(busy_v[1]), .done(done_v[1]), .z(z_v[1]), .cout(cout_v[1]), .ovf(ovf_v[1]));
  y_serial_adder #(.SIZE(1), .DIGIT(1)) u_c (
    .clk(clk), .reset(reset), .start(start_v[2]), .a(a_in[0:0]), .b(b_in[0:0]), .cin(cin_in), .sub(sub_in),
    .busy(busy_v[2]), .done(done_v[2]), .z(z_c), .cout(cout_v[2]), .ovf(ovf_v[2]));
  y_serial_adder #(.SIZE(8), .DIGIT(2)) u_d (
    .clk(clk), .reset(reset), .start(start_v[3]), .a(a_in), .b(b_in), .cin(cin_in), .sub(sub_in),
    .busy(busy_v[3]), .done(done_v[3]), .z(z_v[3]), .cout(cout_v[3]), .ovf(ovf_v[3]));

  assign z_v[2] = {7'b0, z_c};

  typedef struct {
    int         w;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic       b2b;
    logic [7:0] z;
    logic       cout;
    logic       ovf;
  } vec_t;

  vec_t tbl [12];

  function automatic int ncyc(input int w);
    case (w)
      0: return 8;
      1: return 2;
      2: return 1;
      3: return 4;
      default: return 8;
    endcase
  endfunction

  function automatic int width_of(input int w);
    return (w == 2) ? 1 : 8;
  endfunction

  // Reference: {ovf, cout, z} from plain integer arithmetic and the signed-overflow rule.
  function automatic logic [9:0] model(input int w, input logic [7:0] a, input logic [7:0] b,
                                       input logic cin, input logic sub);
    int s, mask, aa, bb, c, sum, zz, co, sa, sb, sz, ov;
    s    = width_of(w);
    mask = (1 << s) - 1;
    aa   = int'(a) & mask;
    bb   = int'(b) & mask;
    c    = int'(cin);
    if (SUB_EN && sub) begin
      bb = (~bb) & mask;
      c  = 1;
    end
    sum = aa + bb + c;
    zz  = sum & mask;
    co  = (sum >> s) & 1;
    sa  = (aa >> (s - 1)) & 1;
    sb  = (bb >> (s - 1)) & 1;
    sz  = (zz >> (s - 1)) & 1;
    ov  = ((sa == sb) && (sz != sa)) ? 1 : 0;
    return {ov[0], co[0], zz[7:0]};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic issue(input int w, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input logic sub);
    a_in       = a;
    b_in       = b;
    cin_in     = cin;
    sub_in     = sub;
    start_v[w] = 1'b1;
    tick();
    start_v[w] = 1'b0;
  endtask

  // Walk the RUN cycles (optionally pulsing start at cycles in 'pulse'), then check DONE.
  task automatic expect_op(input int w, input logic [9:0] exp, input logic [15:0] pulse);
    for (int k = 1; k <= ncyc(w); k++) begin
      chk("busy_in_run", busy_v[w], 1);
      chk("done_in_run", done_v[w], 0);
      if (pulse[k]) begin
        start_v[w] = 1'b1;
        a_in       = 8'($urandom);
        b_in       = 8'($urandom);
      end
      tick();
      start_v[w] = 1'b0;
    end
    chk("done_pulse", done_v[w], 1);
    chk("busy_in_done", busy_v[w], 0);
    chk("z", z_v[w], exp[7:0]);
    chk("cout", cout_v[w], exp[8]);
    chk("ovf", ovf_v[w], exp[9]);
  endtask

  task automatic to_idle(input int w, input logic [7:0] zexp);
    tick();
    chk("done_after", done_v[w], 0);
    chk("busy_after", busy_v[w], 0);
    chk("z_hold", z_v[w], zexp);
  endtask

  initial begin
    logic [9:0] e;
    int         w;
    logic [7:0] ra, rb;
    logic       rc, rs;

    tbl[0]  = '{0, 8'h0F, 8'h01, 1'b0, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
    tbl[1]  = '{1, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0};
    tbl[2]  = '{1, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1};
`ifdef SERIAL_ADDER_SUB_EN
    tbl[3]  = '{3, 8'h05, 8'h07, 1'b0, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0};
`else
    tbl[3]  = '{3, 8'h05, 8'h07, 1'b0, 1'b1, 1'b0, 8'h0C, 1'b0, 1'b0};
`endif
    tbl[4]  = '{2, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[5]  = '{2, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h01, 1'b0, 1'b1};
    tbl[6]  = '{2, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0};
    tbl[7]  = '{2, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[8]  = '{2, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0};
    tbl[9]  = '{2, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[10] = '{2, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[11] = '{2, 8'h01, 8'h01, 1'b1, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0};

    reset   = 1'b1;
    start_v = 4'b0000;
    a_in    = 8'h00;
    b_in    = 8'h00;
    cin_in  = 1'b0;
    sub_in  = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("rst_busy", busy_v[i], 0);
      chk("rst_done", done_v[i], 0);
      chk("rst_z", z_v[i], 0);
      chk("rst_cout", cout_v[i], 0);
      chk("rst_ovf", ovf_v[i], 0);
    end
    reset = 1'b0;
    tick();

    // Directed vectors; b2b entries are issued in the previous DONE cycle.
    for (int i = 0; i < 12; i++) begin
      if (!tbl[i].b2b) tick();
      issue(tbl[i].w, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub);
      expect_op(tbl[i].w, {tbl[i].ovf, tbl[i].cout, tbl[i].z}, 16'h0000);
    end
    to_idle(2, 8'h01);

    // Start pulses at RUN cycles 2 and 5 must be ignored, with no queued operation.
    issue(0, 8'h3C, 8'h0A, 1'b0, 1'b0);
    expect_op(0, 10'h046, 16'b0000_0000_0010_0100);
    to_idle(0, 8'h46);
    tick();
    chk("no_queued_busy", busy_v[0], 0);
    chk("no_queued_done", done_v[0], 0);

    // Reset in RUN cycle 4 abandons the operation and clears results.
    issue(0, 8'h11, 8'h22, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_busy", busy_v[0], 0);
    chk("mid_rst_done", done_v[0], 0);
    chk("mid_rst_z", z_v[0], 0);
    chk("mid_rst_cout", cout_v[0], 0);
    chk("mid_rst_ovf", ovf_v[0], 0);
    issue(0, 8'h02, 8'h03, 1'b0, 1'b0);
    expect_op(0, 10'h005, 16'h0000);
    to_idle(0, 8'h05);

    // Random operations on random instances, sometimes back-to-back.
    for (int i = 0; i < 48; i++) begin
      w  = int'($urandom_range(0, 3));
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      e  = model(w, ra, rb, rc, rs);
      issue(w, ra, rb, rc, rs);
      expect_op(w, e, 16'h0000);
      if ($urandom_range(0, 1) == 1) to_idle(w, e[7:0]);
    end
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
